// File: rtl/avalon_st_pkt_fifo_if.sv
// Avalon-ST beat bundle: valid/ready handshake with data and packet sideband.
// The FIFO takes the slave side on its sink and the master side on its source.
interface avalon_st_pkt_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (
    output valid, data, sop, eop,
    input  ready
  );

  modport slave (
    input  valid, data, sop, eop,
    output ready
  );
endinterface

// File: rtl/avalon_st_pkt_fifo.sv
// Single-clock show-ahead Avalon-ST packet FIFO with fill level,
// almost-full/empty status and optional store-and-forward release.
module avalon_st_pkt_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AF_THRESH     = 12,
  parameter int AE_THRESH     = 2,
  parameter bit STORE_FORWARD = 1'b0
) (
  input  logic                     clk,
  input  logic                     aresetn,
  avalon_st_pkt_fifo_if.slave      snk,
  avalon_st_pkt_fifo_if.master     src,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  typedef logic [AW:0] ptr_t;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t wr_nxt;
  ptr_t rd_nxt;
  ptr_t lvl;
  ptr_t pkt_cnt;

  logic rdy;
  logic rel;
  logic wr;
  logic rd;
  logic empty;
  logic full;
  logic full_nxt;
  logic head_eop;
  logic eop_wr;
  logic eop_rd;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_eop = head[EW-1];

  assign wr = snk.valid & rdy;
  assign rd = src.valid & src.ready;

  assign wr_nxt = wr_ptr + ptr_t'(wr);
  assign rd_nxt = rd_ptr + ptr_t'(rd);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign full_nxt = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) &
                    (wr_nxt[AW] != rd_nxt[AW]);

  assign eop_wr = wr & snk.eop;
  assign eop_rd = rd & head_eop;

  assign snk.ready = rdy;

  // Cut-through shows any stored beat; store-forward waits for a whole
  // packet unless an oversize packet forced the release fallback.
  assign src.valid = !empty &
                     (!STORE_FORWARD | (pkt_cnt != '0) | rel);
  assign src.data  = head[DATA_WIDTH-1:0];
  assign src.sop   = head[EW-2];
  assign src.eop   = head_eop;

  assign level        = lvl;
  assign almost_full  = (lvl >= ptr_t'(AF_THRESH));
  assign almost_empty = (lvl <= ptr_t'(AE_THRESH));

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[AW-1:0]] <= {snk.eop, snk.sop, snk.data};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy    <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      rdy    <= !full_nxt;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lvl <= '0;
    end else begin
      unique case ({wr, rd})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt <= '0;
    end else begin
      unique case ({eop_wr, eop_rd})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // A full FIFO with no complete packet can never drain otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rel <= 1'b0;
    end else if (eop_rd) begin
      rel <= 1'b0;
    end else if (full & (pkt_cnt == '0)) begin
      rel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Directed bench: cut-through and store-forward instances of the FIFO
// driven with hand-computed vectors.
module tb_avalon_st_pkt_fifo;

  localparam int DW = 32;
  localparam int DP = 16;

  logic       clk;
  logic       rst_n;
  logic [4:0] ct_level;
  logic       ct_af;
  logic       ct_ae;
  logic [4:0] sf_level;
  logic       sf_af;
  logic       sf_ae;

  int n_tests;
  int n_fail;

  avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW)) ct_snk ();
  avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW)) ct_src ();
  avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW)) sf_snk ();
  avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW)) sf_src ();

  avalon_st_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(12),
    .AE_THRESH(2), .STORE_FORWARD(1'b0)
  ) u_ct (
    .clk(clk), .aresetn(rst_n),
    .snk(ct_snk.slave), .src(ct_src.master),
    .level(ct_level), .almost_full(ct_af),
    .almost_empty(ct_ae)
  );

  avalon_st_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(12),
    .AE_THRESH(2), .STORE_FORWARD(1'b1)
  ) u_sf (
    .clk(clk), .aresetn(rst_n),
    .snk(sf_snk.slave), .src(sf_src.master),
    .level(sf_level), .almost_full(sf_af),
    .almost_empty(sf_ae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream one packet through the store-forward FIFO with the sink
  // always ready; checks order, framing and fill level at first read.
  task automatic sf_pkt(input int n, input int base);
    int wi, ri, first, cyc;
    bit fw, fr;
    wi = 0; ri = 0; first = -1; cyc = 0;
    sf_src.ready = 1'b1;
    while (ri < n && cyc < 400) begin
      sf_snk.valid = (wi < n);
      sf_snk.data  = DW'(base + wi);
      sf_snk.sop   = (wi == 0);
      sf_snk.eop   = (wi == n - 1);
      fw = sf_snk.valid && sf_snk.ready;
      fr = sf_src.valid && sf_src.ready;
      if (fr) begin
        if (first < 0) first = int'(sf_level);
        chk("sf_data", sf_src.data, DW'(base + ri));
        chk("sf_sop", sf_src.sop, ri == 0);
        chk("sf_eop", sf_src.eop, ri == n - 1);
        ri++;
      end
      if (fw) wi++;
      step();
      cyc++;
    end
    sf_snk.valid = 1'b0;
    chk("sf_beats", ri, n);
    chk("sf_lvl_first_rd", first, (n < DP) ? n : DP);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ct_snk.valid = 0; ct_snk.data = '0;
    ct_snk.sop = 0; ct_snk.eop = 0; ct_src.ready = 0;
    sf_snk.valid = 0; sf_snk.data = '0;
    sf_snk.sop = 0; sf_snk.eop = 0; sf_src.ready = 0;

    // reset
    repeat (3) step();
    chk("rst_rdy", ct_snk.ready, 0);
    chk("rst_sv", ct_src.valid, 0);
    chk("rst_lvl", ct_level, 0);
    chk("rst_ae", ct_ae, 1);
    chk("rst_af", ct_af, 0);
    chk("rst_sf_sv", sf_src.valid, 0);
    rst_n = 1'b1;
    chk("rel_rdy_pre", ct_snk.ready, 0);
    step();
    chk("rel_rdy", ct_snk.ready, 1);
    chk("rel_sf_rdy", sf_snk.ready, 1);

    // fill then drain, cut-through
    for (int i = 0; i < DP; i++) begin
      ct_snk.valid = 1'b1;
      ct_snk.data  = DW'(i);
      step();
      chk("fill_lvl", ct_level, i + 1);
      chk("fill_af", ct_af, (i + 1) >= 12);
      chk("fill_ae", ct_ae, (i + 1) <= 2);
      chk("fill_sv", ct_src.valid, 1);
      chk("fill_head", ct_src.data, 0);
    end
    ct_snk.valid = 1'b0;
    chk("full_rdy", ct_snk.ready, 0);
    ct_src.ready = 1'b1;
    chk("full_rdy_rd", ct_snk.ready, 0);
    for (int i = 0; i < DP; i++) begin
      chk("drain_sv", ct_src.valid, 1);
      chk("drain_data", ct_src.data, i);
      step();
      chk("drain_lvl", ct_level, DP - 1 - i);
      chk("drain_ae", ct_ae, (DP - 1 - i) <= 2);
      chk("drain_rdy", ct_snk.ready, 1);
    end
    chk("drain_sv_end", ct_src.valid, 0);

    // streaming across pointer wrap
    for (int k = 0; k < 100; k++) begin
      ct_snk.valid = 1'b1;
      ct_snk.data  = DW'(1000 + k);
      step();
      chk("strm_lvl", ct_level, 1);
      chk("strm_data", ct_src.data, 1000 + k);
      chk("strm_rdy", ct_snk.ready, 1);
    end
    ct_snk.valid = 1'b0;
    step();
    chk("strm_lvl_end", ct_level, 0);
    chk("strm_sv_end", ct_src.valid, 0);

    // store-forward, slow packet
    sf_src.ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      sf_snk.valid = 1'b1;
      sf_snk.data  = DW'(32'h40 + b);
      sf_snk.sop   = (b == 0);
      sf_snk.eop   = (b == 4);
      step();
      sf_snk.valid = 1'b0;
      chk("sfw_sv", sf_src.valid, b == 4);
      if (b < 4) begin
        repeat (2) begin
          step();
          chk("sfw_sv_gap", sf_src.valid, 0);
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      chk("sfw_rd_sv", sf_src.valid, 1);
      chk("sfw_rd_data", sf_src.data, 32'h40 + j);
      chk("sfw_rd_sop", sf_src.sop, j == 0);
      chk("sfw_rd_eop", sf_src.eop, j == 4);
      step();
    end
    chk("sfw_sv_end", sf_src.valid, 0);
    chk("sfw_lvl_end", sf_level, 0);

    // oversize packet, then a short one must wait for its eop
    sf_pkt(20, 32'h100);
    step();
    chk("ovs_lvl_end", sf_level, 0);
    sf_pkt(3, 32'h200);

    // mid-packet reset
    sf_src.ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      sf_snk.valid = 1'b1;
      sf_snk.data  = DW'(32'h500 + b);
      sf_snk.sop   = (b == 0);
      sf_snk.eop   = 1'b0;
      step();
    end
    sf_snk.valid = 1'b0;
    chk("mid_lvl", sf_level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lvl", sf_level, 0);
    chk("mid_rst_sv", sf_src.valid, 0);
    chk("mid_rst_rdy", sf_snk.ready, 0);
    chk("mid_rst_ae", sf_ae, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_sv", sf_src.valid, 0);
    chk("mid_post_lvl", sf_level, 0);
    sf_pkt(2, 32'h600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
